// File: rtl/mips_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_core_if
//  Description : Instruction / write-back bus between the instruction
//                source (master) and the mips_core execution core (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_core_if;
    logic [31:0] Instr;
    logic [31:0] Data_Out;

    // Instruction source drives the instruction and observes the write-back value
    modport master (
        output Instr,
        input  Data_Out
    );

    // Core consumes the instruction and exposes the write-back value
    modport slave (
        input  Instr,
        output Data_Out
    );
endinterface
`default_nettype wire

// File: rtl/mips_core.sv
`default_nettype none
// ============================================================================
//  Module      : mips_core
//  Description : Single-cycle MIPS-style execution core. Combinational
//                decode, register read, ALU and memory read; register and
//                memory writes commit on the rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_core #(
    parameter int MEM_DEPTH = 64
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mips_core_if.slave  bus
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);

    // Opcodes
    localparam logic [5:0] OP_ADD   = 6'b000001;
    localparam logic [5:0] OP_SUB   = 6'b000010;
    localparam logic [5:0] OP_INC   = 6'b000011;
    localparam logic [5:0] OP_DEC   = 6'b000100;
    localparam logic [5:0] OP_AND   = 6'b000101;
    localparam logic [5:0] OP_OR    = 6'b000110;
    localparam logic [5:0] OP_XOR   = 6'b000111;
    localparam logic [5:0] OP_NOT   = 6'b001000;
    localparam logic [5:0] OP_SLL   = 6'b001001;
    localparam logic [5:0] OP_SRL   = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100010;
    localparam logic [5:0] OP_SW    = 6'b100100;

    // ALU operation encoding
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_INC  = 4'd2;
    localparam logic [3:0] ALU_DEC  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOT  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;

    // Instruction fields
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm_ext;

    assign op      = bus.Instr[31:26];
    assign rs      = bus.Instr[25:21];
    assign rt      = bus.Instr[20:16];
    assign rd      = bus.Instr[15:11];
    assign shamt   = bus.Instr[10:6];
    assign imm_ext = {{16{bus.Instr[15]}}, bus.Instr[15:0]};

    // Control signals
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       shamt_sel;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [3:0] alu_control;

    // Storage
    logic [31:0] regs [32];
    logic [31:0] mem  [MEM_DEPTH];

    // Datapath
    logic [31:0]       rd_a;
    logic [31:0]       rd_b;
    logic [31:0]       opnd_b;
    logic [31:0]       alu_result;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [31:0]       wb_data;
    logic [4:0]        wr_addr;

    // Decode opcode into control; anything unrecognised (including X) is a NOP
    always_comb begin
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src     = 1'b0;
        shamt_sel   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_control = ALU_ADD;
        case (op)
            OP_ADD: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_ADD; end
            OP_SUB: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_SUB; end
            OP_INC: begin reg_write = 1'b1; alu_control = ALU_INC; end
            OP_DEC: begin reg_write = 1'b1; alu_control = ALU_DEC; end
            OP_AND: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_AND; end
            OP_OR:  begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_OR;  end
            OP_XOR: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_XOR; end
            OP_NOT: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_NOT; end
            OP_SLL: begin reg_write = 1'b1; shamt_sel = 1'b1; alu_control = ALU_SLL; end
            OP_SRL: begin reg_write = 1'b1; shamt_sel = 1'b1; alu_control = ALU_SRL; end
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                alu_control = ALU_ADD;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                alu_control = ALU_ADD;
            end
            default: ;
        endcase
    end

    assign rd_a    = regs[rs];
    assign rd_b    = regs[rt];
    assign opnd_b  = shamt_sel ? {27'd0, shamt} : (alu_src ? imm_ext : rd_b);
    assign wr_addr = reg_dst ? rd : rt;

    // ALU: 32-bit modulo arithmetic, logical shifts by the low five bits of B
    always_comb begin
        alu_result = rd_a + opnd_b;
        case (alu_control)
            ALU_ADD: alu_result = rd_a + opnd_b;
            ALU_SUB: alu_result = rd_a - opnd_b;
            ALU_INC: alu_result = rd_a + 32'd1;
            ALU_DEC: alu_result = rd_a - 32'd1;
            ALU_AND: alu_result = rd_a & opnd_b;
            ALU_OR:  alu_result = rd_a | opnd_b;
            ALU_XOR: alu_result = rd_a ^ opnd_b;
            ALU_NOT: alu_result = ~rd_a;
            ALU_SLL: alu_result = rd_a << opnd_b[4:0];
            ALU_SRL: alu_result = rd_a >> opnd_b[4:0];
            default: alu_result = rd_a + opnd_b;
        endcase
    end

    // Word address wraps: only the low bits of the ALU result index memory
    assign mem_addr  = alu_result[ADDR_W-1:0];
    assign mem_rdata = mem[mem_addr];
    assign wb_data   = (mem_to_reg && mem_read) ? mem_rdata : alu_result;

    assign bus.Data_Out = rst ? 32'd0 : wb_data;

    // Register file: clear on reset, otherwise commit the write-back value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (reg_write) begin
            regs[wr_addr] <= wb_data;
        end
    end

    // Data memory: reset loads word i with value i, otherwise commit stores
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 32'(i);
            end
        end else if (mem_write) begin
            mem[mem_addr] <= rd_b;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_core
//  Description : Directed self-checking bench for mips_core. Register
//                contents are observed with an undefined-opcode probe that
//                adds R[r] to R31, which is never written and stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_core;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_ADD = 6'b000001;
    localparam logic [5:0] OP_SUB = 6'b000010;
    localparam logic [5:0] OP_INC = 6'b000011;
    localparam logic [5:0] OP_DEC = 6'b000100;
    localparam logic [5:0] OP_AND = 6'b000101;
    localparam logic [5:0] OP_OR  = 6'b000110;
    localparam logic [5:0] OP_XOR = 6'b000111;
    localparam logic [5:0] OP_NOT = 6'b001000;
    localparam logic [5:0] OP_SLL = 6'b001001;
    localparam logic [5:0] OP_SRL = 6'b001010;
    localparam logic [5:0] OP_LW  = 6'b100010;
    localparam logic [5:0] OP_SW  = 6'b100100;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mips_core_if bus ();

    mips_core #(.MEM_DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {op, rs, rt, rd, sh, 6'b000000};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Present one instruction, sample Data_Out mid-cycle, let it commit
    task automatic exec(input logic [31:0] ins, output logic [31:0] dout);
        bus.Instr = ins;
        @(negedge clk);
        dout = bus.Data_Out;
        @(posedge clk);
        #1;
    endtask

    // Read R[r] through a NOP: Data_Out = R[r] + R31
    task automatic peek(input logic [4:0] r, output logic [31:0] val);
        exec(r_ins(OP_NOP, r, 5'd31, 5'd0, 5'd0), val);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        bus.Instr = r_ins(OP_ADD, 5'd0, 5'd1, 5'd3, 5'd0);
        @(negedge clk);
        checks++;
        if (bus.Data_Out !== 32'd0) begin
            errors++; $display("FAIL reset_dout: got %h expected %h", bus.Data_Out, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        peek(5'd0, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_r0: got %h expected %h", d, 32'd0); end
        peek(5'd3, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_r3: got %h expected %h", d, 32'd0); end
        exec(i_ins(OP_LW, 5'd31, 5'd30, 16'd7), d);
        checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL reset_mem7: got %h expected %h", d, 32'd7); end
    endtask

    task automatic test_load_add();
        logic [31:0] d;
        exec(i_ins(OP_LW, 5'd1, 5'd0, 16'd1), d);
        exec(i_ins(OP_LW, 5'd2, 5'd1, 16'd1), d);
        exec(r_ins(OP_ADD, 5'd0, 5'd1, 5'd3, 5'd0), d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL add_dout: got %h expected %h", d, 32'd2); end
        peek(5'd3, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL add_r3: got %h expected %h", d, 32'd2); end
    endtask

    task automatic test_same_reg_sub();
        logic [31:0] d;
        exec(i_ins(OP_LW, 5'd4, 5'd4, 16'd10), d);
        checks++;
        if (d !== 32'd10) begin errors++; $display("FAIL lw_self_r4: got %h expected %h", d, 32'd10); end
        exec(i_ins(OP_LW, 5'd5, 5'd5, 16'd9), d);
        exec(r_ins(OP_SUB, 5'd4, 5'd5, 5'd6, 5'd0), d);
        peek(5'd6, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL sub_r6: got %h expected %h", d, 32'd1); end
    endtask

    task automatic test_inc_dec();
        logic [31:0] d;
        exec(i_ins(OP_LW, 5'd31, 5'd7, 16'd4), d);
        exec(r_ins(OP_INC, 5'd7, 5'd9, 5'd0, 5'd0), d);
        peek(5'd9, d);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL inc_r9: got %h expected %h", d, 32'd5); end
        exec(i_ins(OP_LW, 5'd31, 5'd8, 16'd5), d);
        exec(r_ins(OP_DEC, 5'd8, 5'd10, 5'd0, 5'd0), d);
        peek(5'd10, d);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL dec_r10: got %h expected %h", d, 32'd4); end
        exec(r_ins(OP_DEC, 5'd31, 5'd24, 5'd0, 5'd0), d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dec_wrap: got %h expected %h", d, 32'hFFFF_FFFF); end
    endtask

    task automatic test_shift();
        logic [31:0] d;
        exec(i_ins(OP_LW, 5'd31, 5'd11, 16'd5), d);
        exec(r_ins(OP_SLL, 5'd11, 5'd12, 5'd0, 5'd2), d);
        peek(5'd12, d);
        checks++;
        if (d !== 32'd20) begin errors++; $display("FAIL sll_r12: got %h expected %h", d, 32'd20); end
        exec(i_ins(OP_LW, 5'd31, 5'd13, 16'd8), d);
        exec(r_ins(OP_SRL, 5'd13, 5'd14, 5'd0, 5'd2), d);
        peek(5'd14, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL srl_r14: got %h expected %h", d, 32'd2); end
    endtask

    task automatic test_store_logic();
        logic [31:0] d;
        exec(i_ins(OP_SW, 5'd31, 5'd12, 16'd30), d);
        checks++;
        if (d !== 32'd30) begin errors++; $display("FAIL sw_dout: got %h expected %h", d, 32'd30); end
        exec(i_ins(OP_LW, 5'd31, 5'd15, 16'd30), d);
        checks++;
        if (d !== 32'd20) begin errors++; $display("FAIL lw_r15: got %h expected %h", d, 32'd20); end
        exec(r_ins(OP_AND, 5'd12, 5'd11, 5'd16, 5'd0), d);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL and: got %h expected %h", d, 32'd4); end
        exec(r_ins(OP_OR, 5'd12, 5'd11, 5'd17, 5'd0), d);
        checks++;
        if (d !== 32'd21) begin errors++; $display("FAIL or: got %h expected %h", d, 32'd21); end
        exec(r_ins(OP_XOR, 5'd12, 5'd11, 5'd18, 5'd0), d);
        checks++;
        if (d !== 32'd17) begin errors++; $display("FAIL xor: got %h expected %h", d, 32'd17); end
        exec(r_ins(OP_NOT, 5'd31, 5'd0, 5'd20, 5'd0), d);
        peek(5'd20, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL not_r20: got %h expected %h", d, 32'hFFFF_FFFF); end
        exec(r_ins(OP_SRL, 5'd20, 5'd21, 5'd0, 5'd28), d);
        checks++;
        if (d !== 32'h0000_000F) begin errors++; $display("FAIL srl_zero_fill: got %h expected %h", d, 32'h0000_000F); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        exec(i_ins(OP_LW, 5'd31, 5'd22, 16'hFFFF), d);
        checks++;
        if (d !== 32'd63) begin errors++; $display("FAIL wrap_neg: got %h expected %h", d, 32'd63); end
        exec(i_ins(OP_LW, 5'd31, 5'd22, 16'd67), d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL wrap_pos: got %h expected %h", d, 32'd3); end
    endtask

    task automatic test_nop();
        logic [31:0] d;
        exec(r_ins(OP_NOP, 5'd3, 5'd3, 5'd3, 5'd0), d);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL nop_dout: got %h expected %h", d, 32'd4); end
        exec(i_ins(6'b111111, 5'd31, 5'd3, 16'd5), d);
        exec(32'hxxxx_xxxx, d);
        peek(5'd3, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL nop_r3: got %h expected %h", d, 32'd2); end
        exec(i_ins(OP_LW, 5'd31, 5'd30, 16'd5), d);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL nop_mem5: got %h expected %h", d, 32'd5); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        exec(r_ins(OP_INC, 5'd31, 5'd23, 5'd0, 5'd0), d);
        exec(r_ins(OP_INC, 5'd23, 5'd23, 5'd0, 5'd0), d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL b2b_inc2: got %h expected %h", d, 32'd2); end
        exec(r_ins(OP_INC, 5'd23, 5'd23, 5'd0, 5'd0), d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL b2b_inc3: got %h expected %h", d, 32'd3); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        rst = 1'b1;
        bus.Instr = i_ins(OP_SW, 5'd31, 5'd12, 16'd5);
        @(negedge clk);
        checks++;
        if (bus.Data_Out !== 32'd0) begin
            errors++; $display("FAIL mid_rst_dout: got %h expected %h", bus.Data_Out, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        peek(5'd3, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL mid_rst_r3: got %h expected %h", d, 32'd0); end
        peek(5'd12, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL mid_rst_r12: got %h expected %h", d, 32'd0); end
        exec(i_ins(OP_LW, 5'd31, 5'd30, 16'd30), d);
        checks++;
        if (d !== 32'd30) begin errors++; $display("FAIL mid_rst_mem30: got %h expected %h", d, 32'd30); end
        exec(i_ins(OP_LW, 5'd31, 5'd30, 16'd5), d);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL mid_rst_mem5: got %h expected %h", d, 32'd5); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.Instr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_add();
        test_same_reg_sub();
        test_inc_dec();
        test_shift();
        test_store_logic();
        test_wrap();
        test_nop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
